rr_arb3: RTL and testbench

Three-way round-robin arbiter that shares one resource among three requesters. Its priority pointer is a mod-3 cyclic counter (0→1→2→0) and must never reach encoding 3. The block grants at most one requester at a time and enforces a maximum hold time. It exposes a `bad` invariant output for the model-checking flow; this output must stay 0 on every reachable state.

---
 rtl/rr_arb_pkg.sv | 68 ++++++
 rtl/rr_ptr3.sv | 34 +++
 rtl/rr_arb3.sv | 125 ++++++++++++
 tb/tb_rr_arb3.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the three-way round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned NREQ = 3;
    localparam int unsigned IDW  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Result of one round-robin search.
    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] idx;
    } pick_t;

    // Mod-3 successor; the unused code 3 folds back to 0.
    function automatic logic [IDW-1:0] mod3_inc(input logic [IDW-1:0] v);
        logic [IDW-1:0] r;
        case (v)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // One-hot decode of a requester index; code 3 decodes to no grant.
    function automatic logic [NREQ-1:0] onehot3(input logic [IDW-1:0] i);
        logic [NREQ-1:0] r;
        case (i)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // First set request searching ptr, ptr+1, ptr+2 (mod 3).
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                      input logic [IDW-1:0]  ptr);
        pick_t          r;
        logic [IDW-1:0] i0;
        logic [IDW-1:0] i1;
        logic [IDW-1:0] i2;
        i0 = (ptr == 2'd3) ? 2'd0 : ptr;
        i1 = mod3_inc(i0);
        i2 = mod3_inc(i1);
        r  = '0;
        // Lowest search priority first so higher priority overwrites.
        if (req[i2]) begin
            r.valid = 1'b1;
            r.idx   = i2;
        end
        if (req[i1]) begin
            r.valid = 1'b1;
            r.idx   = i1;
        end
        if (req[i0]) begin
            r.valid = 1'b1;
            r.idx   = i0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_ptr3.sv
// Mod-3 priority pointer: on enable loads the successor of base, never holds 3.
module rr_ptr3
    import rr_arb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [IDW-1:0] base,
    output logic [IDW-1:0] ptr
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // Next pointer: successor of the released grantee, else hold.
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = mod3_inc(base);
        end
    end

    // Pointer register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter with bounded hold time and invariant flag.
module rr_arb3
    import rr_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned HW       = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic [IDW-1:0]  ptr,
    output logic            bad
);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_MAX);

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic            busy_q, busy_d;
    logic [IDW-1:0]  ptr_q;
    logic            ptr_en_c;
    logic            rel_c;
    pick_t           pick_c;

    // Priority pointer, advanced only when a grant is released.
    rr_ptr3 u_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (ptr_en_c),
        .base  (gnt_id_q),
        .ptr   (ptr_q)
    );

    // Next-state, grant and hold computation.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        ptr_en_c = 1'b0;
        pick_c   = rr_pick(req, ptr_q);
        rel_c    = done[gnt_id_q] | ~req[gnt_id_q] | (hold_q == HOLD_LAST);
        case (state_q)
            IDLE: begin
                if (pick_c.valid) begin
                    state_d  = GRANT;
                    gnt_d    = onehot3(pick_c.idx);
                    gnt_id_d = pick_c.idx;
                    busy_d   = 1'b1;
                    hold_d   = '0;
                end
            end
            GRANT: begin
                if (rel_c) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                    hold_d   = '0;
                    ptr_en_c = 1'b1;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                hold_d   = '0;
            end
        endcase
    end

    // State, hold and grant registers; reset overrides any grant in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
        end
    end

    // Invariant flag: any of these means an unreachable state was entered.
    always_comb begin
        bad = 1'b0;
        if (ptr_q == 2'd3) begin
            bad = 1'b1;
        end
        if ((gnt_q & (gnt_q - 3'd1)) != 3'd0) begin
            bad = 1'b1;
        end
        if (busy_q != (gnt_q != 3'd0)) begin
            bad = 1'b1;
        end
        if ((gnt_q != 3'd0) && (gnt_q != onehot3(gnt_id_q))) begin
            bad = 1'b1;
        end
        if (hold_q >= HOLD_LIM) begin
            bad = 1'b1;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;
    assign ptr    = ptr_q;

endmodule

// File: tb/tb_rr_arb3.sv
// Directed bench for rr_arb3: rotation, release causes, ignored done bits, reset mid-grant.
module tb_rr_arb3;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [1:0] ptr;
    logic       bad;

    int checks;
    int failures;

    rr_arb3 #(.HOLD_MAX(4), .HW(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .ptr    (ptr),
        .bad    (bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all outputs against expected values; bad must always be 0.
    task automatic chk(input string tag, input logic [2:0] eg, input logic [1:0] eid,
                       input logic eb, input logic [1:0] ep);
        checks++;
        assert (gnt === eg) else begin
            failures++;
            $error("FAIL %s.gnt observed=%b expected=%b", tag, gnt, eg);
        end
        checks++;
        assert (gnt_id === eid) else begin
            failures++;
            $error("FAIL %s.gnt_id observed=%0d expected=%0d", tag, gnt_id, eid);
        end
        checks++;
        assert (busy === eb) else begin
            failures++;
            $error("FAIL %s.busy observed=%b expected=%b", tag, busy, eb);
        end
        checks++;
        assert (ptr === ep) else begin
            failures++;
            $error("FAIL %s.ptr observed=%0d expected=%0d", tag, ptr, ep);
        end
        checks++;
        assert (bad === 1'b0) else begin
            failures++;
            $error("FAIL %s.bad observed=%b expected=0", tag, bad);
        end
    endtask

    initial begin
        logic [2:0] g;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        req      = 3'b000;
        done     = 3'b000;

        // Reset for two edges.
        @(negedge clk);
        @(negedge clk);
        chk("reset", 3'b000, 2'd0, 1'b0, 2'd0);

        // All requesting: rotate 0,1,2,0 with 4-cycle holds and one idle cycle.
        reset = 1'b1;
        req   = 3'b111;
        for (int r = 0; r < 4; r++) begin
            g = 3'b001 << (r % 3);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk($sformatf("rot%0d_hold%0d", r, k), g, 2'(r % 3), 1'b1, 2'(r % 3));
            end
            @(negedge clk);
            chk($sformatf("rot%0d_idle", r), 3'b000, 2'd0, 1'b0, 2'((r + 1) % 3));
        end
        req = 3'b000;

        // Return pointer to 0.
        reset = 1'b0;
        @(negedge clk);
        chk("reset2", 3'b000, 2'd0, 1'b0, 2'd0);

        // Single requester 1, released by done.
        reset = 1'b1;
        req   = 3'b010;
        @(negedge clk);
        chk("req1_grant", 3'b010, 2'd1, 1'b1, 2'd0);
        done = 3'b010;
        @(negedge clk);
        chk("req1_done", 3'b000, 2'd0, 1'b0, 2'd2);

        // ptr=2, req=011: search order 2,0,1 picks 0.
        done = 3'b000;
        req  = 3'b011;
        @(negedge clk);
        chk("order_201", 3'b001, 2'd0, 1'b1, 2'd2);

        // Release 0 by done, then grant 2 alone.
        done = 3'b001;
        @(negedge clk);
        chk("rel0_done", 3'b000, 2'd0, 1'b0, 2'd1);
        done = 3'b000;
        req  = 3'b100;
        @(negedge clk);
        chk("grant2", 3'b100, 2'd2, 1'b1, 2'd1);

        // Grantee 2 drops its request while 0 and 1 request.
        req = 3'b011;
        @(negedge clk);
        chk("drop2_rel", 3'b000, 2'd0, 1'b0, 2'd0);
        @(negedge clk);
        chk("drop2_next", 3'b001, 2'd0, 1'b1, 2'd0);

        // Drop requester 0, then grant 1.
        req = 3'b010;
        @(negedge clk);
        chk("drop0_rel", 3'b000, 2'd0, 1'b0, 2'd1);
        @(negedge clk);
        chk("grant1", 3'b010, 2'd1, 1'b1, 2'd1);

        // done bits of non-grantees are ignored.
        done = 3'b101;
        @(negedge clk);
        chk("done_other", 3'b010, 2'd1, 1'b1, 2'd1);
        done = 3'b010;
        @(negedge clk);
        chk("done_own", 3'b000, 2'd0, 1'b0, 2'd2);
        done = 3'b000;

        // Reset mid-grant to 2 at hold=2.
        req = 3'b100;
        @(negedge clk);
        chk("g2_h0", 3'b100, 2'd2, 1'b1, 2'd2);
        @(negedge clk);
        chk("g2_h1", 3'b100, 2'd2, 1'b1, 2'd2);
        @(negedge clk);
        chk("g2_h2", 3'b100, 2'd2, 1'b1, 2'd2);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mid", 3'b000, 2'd0, 1'b0, 2'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_grant", 3'b100, 2'd2, 1'b1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
